// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, stall bit indices,
// FSM states and the zero word.
package pipe_ctrl_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STALL_BIT_PC    = 0;
  localparam int unsigned STALL_BIT_IFID  = 1;
  localparam int unsigned STALL_BIT_IDEX  = 2;
  localparam int unsigned STALL_BIT_EXMEM = 3;
  localparam int unsigned STALL_BIT_MEMWB = 4;
  localparam int unsigned STALL_BIT_RSVD  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // Deepest requesting stage wins; a request freezes its own stage and everything upstream.
  function automatic logic [STALL_W-1:0] stall_merge(input logic req_if, input logic req_id,
                                                     input logic req_ex, input logic req_mem);
    logic [STALL_W-1:0] v;
    v = STALL_NONE;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages/divider and the sequencer.
// PIPE_CTRL_PERF_EN adds the stall_cycles/flush_count performance counters.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic               div_req;
  logic               div_done;
  logic               excp_valid;
  logic [31:0]        excp_handler;
  logic               eret_valid;
  logic [31:0]        epc;

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        new_pc;
  logic               div_start;
  logic               div_annul;
  logic               div_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]        stall_cycles;
  logic [31:0]        flush_count;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           div_req, div_done, excp_valid, excp_handler, eret_valid, epc,
    input  stall, flush, new_pc, div_start, div_annul, div_timeout
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, flush_count
`endif
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
           div_req, div_done, excp_valid, excp_handler, eret_valid, epc,
    output stall, flush, new_pc, div_start, div_annul, div_timeout
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/pipe_ctrl_div_watchdog.sv
// Divide watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches LIMIT.
module pipe_ctrl_div_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                         cnt_d = '0;
    else if (en_i && cnt_q != CW'(LIMIT)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires on the cycle whose increment would make the count reach LIMIT.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, divider handshake with watchdog, and
// exception/eret flush + redirect. PIPE_CTRL_PERF_EN enables perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned DIV_MAX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  state_e             state_q;
  logic               flush_q;
  logic [31:0]        new_pc_q;
  logic               div_start_q;
  logic               div_annul_q;
  logic               div_timeout_q;
  logic [FW-1:0]      fcnt_q;

  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               flush_entry;
  logic               div_launch;
  logic               wd_expired;
  logic [STALL_W-1:0] stall_vec;

  assign redirect    = bus.excp_valid || bus.eret_valid;
  assign redirect_pc = bus.excp_valid ? bus.excp_handler : bus.epc;
  assign flush_entry = redirect && (state_q != ST_FLUSH);
  assign div_launch  = (state_q == ST_IDLE) && !redirect && bus.div_req;

  always_comb begin
    stall_vec = STALL_NONE;
    if (state_q != ST_FLUSH) begin
      stall_vec = stall_merge(bus.stallreq_if, bus.stallreq_id,
                              bus.stallreq_ex || (state_q == ST_DIV_WAIT) ||
                              ((state_q == ST_IDLE) && bus.div_req),
                              bus.stallreq_mem);
    end
  end

  pipe_ctrl_div_watchdog #(
    .LIMIT (DIV_MAX_CYCLES)
  ) u_div_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (div_launch),
    .en_i      (state_q == ST_DIV_WAIT),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      flush_q       <= 1'b0;
      new_pc_q      <= ZeroWord;
      div_start_q   <= 1'b0;
      div_annul_q   <= 1'b0;
      div_timeout_q <= 1'b0;
      fcnt_q        <= '0;
    end else begin
      div_start_q <= 1'b0;
      div_annul_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= redirect_pc;
            fcnt_q   <= FW'(FLUSH_CYCLES - 1);
          end else if (bus.div_req) begin
            state_q     <= ST_DIV_WAIT;
            div_start_q <= 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          // A redirect aborts the divide even when div_done arrives in the same cycle.
          if (redirect) begin
            state_q     <= ST_FLUSH;
            flush_q     <= 1'b1;
            new_pc_q    <= redirect_pc;
            fcnt_q      <= FW'(FLUSH_CYCLES - 1);
            div_annul_q <= 1'b1;
          end else if (bus.div_done) begin
            state_q <= ST_IDLE;
          end else if (wd_expired) begin
            state_q       <= ST_IDLE;
            div_annul_q   <= 1'b1;
            div_timeout_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall       = stall_vec;
  assign bus.flush       = flush_q;
  assign bus.new_pc      = new_pc_q;
  assign bus.div_start   = div_start_q;
  assign bus.div_annul   = div_annul_q;
  assign bus.div_timeout = div_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_vec[STALL_BIT_PC]) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_entry)             flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned FC   = 3;
  localparam int unsigned DMAX = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .FLUSH_CYCLES   (FC),
    .DIV_MAX_CYCLES (DMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: flush_left counts remaining redirect cycles, busy/age track a divide.
  int          flush_left;
  bit          busy;
  int          age;
  logic [31:0] m_pc;
  bit          m_start, m_annul, m_to;
  logic [31:0] m_stallcyc, m_flushcnt;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_stall();
    if (flush_left > 0)                                  return 6'b000000;
    if (bus.stallreq_mem)                                return 6'b011111;
    if (bus.stallreq_ex || busy || bus.div_req)          return 6'b001111;
    if (bus.stallreq_id)                                 return 6'b000111;
    if (bus.stallreq_if)                                 return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_edge();
    logic [5:0] s;
    s = exp_stall();
    if (rst) begin
      flush_left = 0; busy = 0; age = 0; m_pc = 32'h0;
      m_start = 0; m_annul = 0; m_to = 0;
      m_stallcyc = 0; m_flushcnt = 0;
    end else begin
      m_start = 0; m_annul = 0;
      if (s[0]) m_stallcyc = m_stallcyc + 1;
      if (flush_left > 0) begin
        flush_left--;
      end else if (bus.excp_valid || bus.eret_valid) begin
        if (busy) m_annul = 1;
        busy = 0;
        flush_left = FC;
        m_pc = bus.excp_valid ? bus.excp_handler : bus.epc;
        m_flushcnt = m_flushcnt + 1;
      end else if (busy) begin
        age++;
        if (bus.div_done) busy = 0;
        else if (age == DMAX) begin busy = 0; m_annul = 1; m_to = 1; end
      end else if (bus.div_req) begin
        busy = 1; age = 0; m_start = 1;
      end
    end
  endtask

  // One clock: check combinational stall mid-cycle, advance model at the edge, check registers after it.
  task automatic cycle();
    #3;
    check("stall", {26'h0, bus.stall}, {26'h0, exp_stall()});
    @(posedge clk);
    model_edge();
    #1;
    check("flush",       {31'h0, bus.flush},       {31'h0, flush_left > 0});
    check("new_pc",      bus.new_pc,               m_pc);
    check("div_start",   {31'h0, bus.div_start},   {31'h0, m_start});
    check("div_annul",   {31'h0, bus.div_annul},   {31'h0, m_annul});
    check("div_timeout", {31'h0, bus.div_timeout}, {31'h0, m_to});
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles", bus.stall_cycles, m_stallcyc);
    check("flush_count",  bus.flush_count,  m_flushcnt);
`endif
  endtask

  task automatic clear_inputs();
    bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.div_req = 0; bus.div_done = 0; bus.excp_valid = 0; bus.eret_valid = 0;
    bus.excp_handler = 32'h0; bus.epc = 32'h0;
  endtask

  initial begin
    flush_left = 0; busy = 0; age = 0; m_pc = 0;
    m_start = 0; m_annul = 0; m_to = 0; m_stallcyc = 0; m_flushcnt = 0;
    clear_inputs();
    rst = 1;
    #1;
    cycle(); cycle();
    rst = 0;

    // Stall merge
    bus.stallreq_id = 1; cycle();
    check("stall_id", {26'h0, bus.stall}, 32'h07);
    bus.stallreq_mem = 1; cycle();
    bus.stallreq_if = 1; bus.stallreq_id = 0; bus.stallreq_mem = 0; cycle();
    bus.stallreq_ex = 1; cycle();
    clear_inputs(); cycle();

    // Divide completing after 35 cycles
    bus.div_req = 1; cycle();
    check("div_start_pulse", {31'h0, bus.div_start}, 32'h1);
    for (int i = 0; i < 34; i++) cycle();
    bus.div_done = 1; cycle();
    bus.div_done = 0; bus.div_req = 0; cycle();
    check("div_released", {26'h0, bus.stall}, 32'h0);

    // Exception from IDLE; a second one during the flush is ignored
    bus.stallreq_mem = 1; bus.excp_valid = 1; bus.excp_handler = 32'h8000_0180; cycle();
    bus.excp_handler = 32'h1234_5678; cycle();
    check("excp_new_pc", bus.new_pc, 32'h8000_0180);
    clear_inputs();
    for (int i = 0; i < FC + 1; i++) cycle();

    // eret aborts a running divide; a late div_done is ignored
    bus.div_req = 1; cycle();
    for (int i = 0; i < 5; i++) cycle();
    bus.eret_valid = 1; bus.epc = 32'hBFC0_0010; cycle();
    check("eret_new_pc", bus.new_pc, 32'hBFC0_0010);
    clear_inputs(); bus.div_done = 1; cycle();
    bus.div_done = 0;
    for (int i = 0; i < FC + 1; i++) cycle();

    // Watchdog expiry
    bus.div_req = 1; cycle();
    for (int i = 0; i < DMAX - 1; i++) cycle();
    bus.div_req = 0; cycle();
    check("timeout_annul", {31'h0, bus.div_annul}, 32'h1);
    cycle(); cycle();
    check("timeout_sticky", {31'h0, bus.div_timeout}, 32'h1);

    // Reset mid-divide
    bus.div_req = 1; cycle(); cycle(); cycle();
    bus.div_req = 0; rst = 1; cycle();
    rst = 0; cycle();

    // Exception and div_done together
    bus.div_req = 1; cycle();
    for (int i = 0; i < 10; i++) cycle();
    bus.excp_valid = 1; bus.div_done = 1; bus.excp_handler = 32'h8000_0180; cycle();
    check("excp_done_annul", {31'h0, bus.div_annul}, 32'h1);
    clear_inputs();
    for (int i = 0; i < FC + 1; i++) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.stallreq_if  = ($urandom_range(0, 6) == 0);
      bus.stallreq_id  = ($urandom_range(0, 6) == 0);
      bus.stallreq_ex  = ($urandom_range(0, 9) == 0);
      bus.stallreq_mem = ($urandom_range(0, 9) == 0);
      bus.div_req      = ($urandom_range(0, 3) == 0);
      bus.div_done     = ($urandom_range(0, 19) == 0);
      bus.excp_valid   = ($urandom_range(0, 29) == 0);
      bus.eret_valid   = ($urandom_range(0, 29) == 0);
      bus.excp_handler = $urandom;
      bus.epc          = $urandom;
      rst              = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; clear_inputs(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
